tt_lut_eval: RTL and testbench

TT_LUT_EVAL -- requirements
Module: tt_lut_eval

---
 rtl/tt_lut_pkg.sv | 14 +
 rtl/tt_lut_store.sv | 58 +++++
 rtl/tt_lut_eval.sv | 129 ++++++++++++
 tb/tb_tt_lut_eval.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_lut_pkg.sv
// Shared types and defaults for the truth-table LUT evaluator.
package tt_lut_pkg;

   typedef enum logic {RUN, LOAD} tt_state_e;

   localparam int unsigned   TT_N_IN_DEF  = 4;
   localparam int unsigned   TT_CFG_W_DEF = 4;
   localparam logic [15:0]   TT_INIT_DEF  = 16'h6847;

   function automatic int unsigned tt_beats(input int unsigned n_in, input int unsigned cfg_w);
      return (32'd1 << n_in) / cfg_w;
   endfunction

endpackage

// File: rtl/tt_lut_store.sv
// Active/shadow truth-table storage: beat-wise shadow writes and atomic commit.
module tt_lut_store
   import tt_lut_pkg::*;
#(
   parameter int unsigned             N_IN    = TT_N_IN_DEF,
   parameter int unsigned             CFG_W   = TT_CFG_W_DEF,
   parameter logic [(1<<N_IN)-1:0]    TT_INIT = TT_INIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   restart,
   input  logic                   wr_en,
   input  logic [CFG_W-1:0]       wr_data,
   output logic                   last_beat,
   output logic [(1<<N_IN)-1:0]   table_w
);

   localparam int unsigned BEATS = tt_beats(N_IN, CFG_W);
   localparam int unsigned KW    = $clog2(BEATS) + 1;

   logic [(1<<N_IN)-1:0] active_q, active_d;
   logic [(1<<N_IN)-1:0] shadow_q, shadow_d;
   logic [KW-1:0]        k_q, k_d;

   assign last_beat = (k_q == KW'(BEATS - 1));
   assign table_w   = active_q;

   always_comb begin
      active_d = active_q;
      shadow_d = shadow_q;
      k_d      = k_q;
      if (restart) begin
         k_d = '0;
      end else if (wr_en) begin
         shadow_d[int'(k_q) * CFG_W +: CFG_W] = wr_data;
         // Commit includes the final beat being written on this edge.
         if (last_beat) begin
            active_d = shadow_d;
            k_d      = '0;
         end else begin
            k_d = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= TT_INIT;
         shadow_q <= TT_INIT;
         k_q      <= '0;
      end else begin
         active_q <= active_d;
         shadow_q <= shadow_d;
         k_q      <= k_d;
      end
   end

endmodule

// File: rtl/tt_lut_eval.sv
// Truth-table LUT evaluator: RUN/LOAD FSM, query handshake and registered result.
// Optional TT_LUT_COUNT_EN adds ones_cnt, a saturating count of delivered 1-results.
module tt_lut_eval
   import tt_lut_pkg::*;
#(
   parameter int unsigned             N_IN    = TT_N_IN_DEF,
   parameter int unsigned             CFG_W   = TT_CFG_W_DEF,
   parameter logic [(1<<N_IN)-1:0]    TT_INIT = TT_INIT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_start,
   input  logic               cfg_valid,
   input  logic [CFG_W-1:0]   cfg_data,
   output logic               cfg_ready,
   input  logic               in_valid,
   input  logic [N_IN-1:0]    in_vec,
   output logic               in_ready,
   output logic               out_valid,
   output logic               out_bit,
   input  logic               out_ready,
   output logic               busy
`ifdef TT_LUT_COUNT_EN
   ,
   output logic [15:0]        ones_cnt
`endif
);

   tt_state_e state_q, state_d;
   logic      out_valid_q, out_valid_d;
   logic      out_bit_q, out_bit_d;
   logic      restart, wr_en, last_beat, commit;
   logic [(1<<N_IN)-1:0] table_w;

   tt_lut_store #(
      .N_IN    (N_IN),
      .CFG_W   (CFG_W),
      .TT_INIT (TT_INIT)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .wr_en     (wr_en),
      .wr_data   (cfg_data),
      .last_beat (last_beat),
      .table_w   (table_w)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      restart   = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         RUN: begin
            in_ready = !cfg_start && (!out_valid_q || out_ready);
            if (cfg_start) begin
               state_d = LOAD;
               restart = 1'b1;
            end
         end
         LOAD: begin
            cfg_ready = 1'b1;
            busy      = 1'b1;
            if (cfg_start) begin
               restart = 1'b1;
            end else if (cfg_valid) begin
               wr_en = 1'b1;
               if (last_beat) state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign commit = wr_en && last_beat;

   always_comb begin
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      if (in_valid && in_ready) begin
         out_valid_d = 1'b1;
         out_bit_d   = table_w[in_vec];
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;

`ifdef TT_LUT_COUNT_EN
   logic [15:0] ones_cnt_q, ones_cnt_d;

   always_comb begin
      ones_cnt_d = ones_cnt_q;
      if (commit) begin
         ones_cnt_d = '0;
      end else if (out_valid_q && out_ready && out_bit_q && (ones_cnt_q != '1)) begin
         ones_cnt_d = ones_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ones_cnt_q <= '0;
      else     ones_cnt_q <= ones_cnt_d;
   end

   assign ones_cnt = ones_cnt_q;
`else
   logic unused_commit;
   assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_tt_lut_eval.sv
// Self-checking bench for tt_lut_eval: vector table plus scoreboard of expected result bits.
module tb_tt_lut_eval;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_start, cfg_valid, cfg_ready;
   logic [3:0] cfg_data;
   logic       in_valid, in_ready;
   logic [3:0] in_vec;
   logic       out_valid, out_bit, out_ready;
   logic       busy;
`ifdef TT_LUT_COUNT_EN
   logic [15:0] ones_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit exp_q[$];
   bit acc_prev = 1'b0;

   typedef struct {
      logic [3:0] vec;
      logic       exp;
   } vec_t;

   always #5 clk = ~clk;

   tt_lut_eval #(
      .N_IN    (4),
      .CFG_W   (4),
      .TT_INIT (16'h6847)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .in_valid  (in_valid),
      .in_vec    (in_vec),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef TT_LUT_COUNT_EN
      ,
      .ones_cnt  (ones_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: pops one expected bit per delivered result.
   always @(negedge clk) begin
      if (!rst) begin
         if (acc_prev) chk("latency_out_valid", 32'(out_valid), 32'd1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               chk("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
            end
         end
         acc_prev = in_valid && in_ready;
      end else begin
         acc_prev = 1'b0;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      tick();
      tick();
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic query(input logic [3:0] v, input logic e);
      int n = 0;
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_vec   = v;
      while (!ok && n < 20) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            ok = 1'b1;
         end
         tick();
         n++;
      end
      if (!ok) chk("query_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 50; n++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load(input logic [3:0] b[4], input int nb);
      cfg_start = 1'b1;
      @(negedge clk);
      chk("start_in_ready", 32'(in_ready), 32'd0);
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < nb; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = b[i];
         @(negedge clk);
         chk("load_busy", 32'(busy), 32'd1);
         chk("load_cfg_ready", 32'(cfg_ready), 32'd1);
         chk("load_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      cfg_valid = 1'b0;
      if (nb == 4) begin
         @(negedge clk);
         chk("busy_after_load", 32'(busy), 32'd0);
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[6];
      logic [3:0] b_8001[4];
      logic [3:0] b_ff[4];
      logic [3:0] b_zero[4];
      logic [15:0] init_tt;

      tbl[0] = '{4'd0,  1'b1};
      tbl[1] = '{4'd3,  1'b0};
      tbl[2] = '{4'd6,  1'b1};
      tbl[3] = '{4'd11, 1'b1};
      tbl[4] = '{4'd14, 1'b1};
      tbl[5] = '{4'd15, 1'b0};
      b_8001 = '{4'h1, 4'h0, 4'h0, 4'h8};
      b_ff   = '{4'hF, 4'hF, 4'hF, 4'hF};
      b_zero = '{4'h0, 4'h0, 4'h0, 4'h0};
      init_tt = 16'h6847;

      do_reset();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bit", 32'(out_bit), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      tick();

      // Reset table, back-to-back queries
      for (int i = 0; i < 6; i++) query(tbl[i].vec, tbl[i].exp);
      drain();

      // Backpressure holds result, release accepts next query in the same cycle
      query(4'd0, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_vec    = 4'd6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_bit", 32'(out_bit), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) exp_q.push_back(1'b1);
      tick();
      in_valid = 1'b0;
      drain();

      // cfg_valid in RUN is ignored
      cfg_valid = 1'b1;
      cfg_data  = 4'hF;
      @(negedge clk);
      chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
      tick();
      cfg_valid = 1'b0;

      // Load 16'h8001
      load(b_8001, 4);
      query(4'd0, 1'b1);
      query(4'd5, 1'b0);
      query(4'd15, 1'b1);
      drain();

      // Aborted partial load then full zero load
      load(b_ff, 2);
      load(b_zero, 4);
      for (int v = 0; v < 16; v++) query(4'(v), 1'b0);
      drain();

      // Reset mid-load restores TT_INIT
      load(b_zero, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midload_rst_busy", 32'(busy), 32'd0);
      tick();
      query(4'd14, 1'b1);
      drain();

      // Registered result survives a load and drains afterwards
      query(4'd14, 1'b1);
      out_ready = 1'b0;
      load(b_zero, 4);
      @(negedge clk);
      chk("held_across_load", 32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b1;
      drain();
      query(4'd14, 1'b0);
      drain();

`ifdef TT_LUT_COUNT_EN
      do_reset();
      for (int v = 0; v < 16; v++) query(4'(v), init_tt[v]);
      drain();
      tick();
      chk("ones_cnt_init", 32'(ones_cnt), 32'd7);
      load(b_8001, 4);
      chk("ones_cnt_cleared", 32'(ones_cnt), 32'd0);
`else
      init_tt = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
